// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and baud-rate helper
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_ODD  = 2'd1,
    PAR_EVEN = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_e;

  // Rounded clocks per bit; also used by the receiver.
  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// rtl/uart_fifo.sv - synchronous FIFO with first-word fall-through read data
module uart_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       wdata_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  // A push while full is dropped even if a pop frees a slot on the same edge.
  assign full_o  = count_q == (AW + 1)'(DEPTH);
  assign empty_o = count_q == '0;
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - FIFO-buffered UART transmitter with configurable frame format
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115_200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        clk_50M,
  input  logic                        rst_n,
  input  logic [DATA_BITS-1:0]        in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic                        tx,
  output logic                        busy,
  output logic                        frame_done,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int   CPB     = clks_per_bit(CLK_HZ, BAUD);
  localparam int   TW      = $clog2(CPB + 1);
  localparam int   CW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic HAS_PAR = (PARITY != int'(PAR_NONE));
  localparam logic PAR_INV = (PARITY == int'(PAR_ODD));

  if (DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
      STOP_BITS < 1 || STOP_BITS > 2 || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_params
    $error("uart_tx_fifo: illegal DATA_BITS/PARITY/STOP_BITS/FIFO_DEPTH");
  end

  tx_state_e            state_q, state_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [3:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 load;
  logic                 bit_end;
  logic                 push_en;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [DATA_BITS-1:0] fifo_rdata;

  uart_fifo #(
    .WIDTH(DATA_BITS),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (clk_50M),
    .rst_ni (rst_n),
    .push_i (in_valid),
    .wdata_i(in_data),
    .pop_i  (load),
    .rdata_o(fifo_rdata),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .count_o(fifo_count)
  );

  assign in_ready   = !fifo_full;
  assign push_en    = in_valid && !fifo_full;
  assign bit_end    = timer_q == TW'(CPB - 1);
  assign tx         = tx_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    par_d   = par_q;
    bit_d   = bit_q;
    timer_d = timer_q;
    load    = 1'b0;
    case (state_q)
      TX_IDLE:   load = !fifo_empty;
      TX_START:  if (bit_end) state_d = TX_DATA;
      TX_DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_q == 4'(DATA_BITS - 1)) state_d = HAS_PAR ? TX_PARITY : TX_STOP;
          else                             bit_d   = bit_q + 1'b1;
        end
      end
      TX_PARITY: if (bit_end) state_d = TX_STOP;
      TX_STOP: begin
        // The last stop cycle chains straight into the next start bit when words are queued.
        if (bit_end) begin
          if (bit_q == 4'(STOP_BITS - 1)) begin
            load = !fifo_empty;
            if (fifo_empty) state_d = TX_IDLE;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      default:   state_d = TX_IDLE;
    endcase

    if (load) begin
      state_d = TX_START;
      shift_d = fifo_rdata;
      par_d   = (^fifo_rdata) ^ PAR_INV;
    end

    if (state_d != state_q) begin
      timer_d = '0;
      bit_d   = '0;
    end else if (bit_end || state_q == TX_IDLE) begin
      timer_d = '0;
    end else begin
      timer_d = timer_q + 1'b1;
    end

    case (state_d)
      TX_START:  tx_d = 1'b0;
      TX_DATA:   tx_d = shift_d[0];
      TX_PARITY: tx_d = par_d;
      default:   tx_d = 1'b1;
    endcase

    busy_d = (state_d != TX_IDLE) || push_en || (fifo_count > CW'(1)) ||
             (fifo_count == CW'(1) && !load);
    done_d = (state_d == TX_STOP) && (timer_d == TW'(CPB - 1)) &&
             (bit_d == 4'(STOP_BITS - 1));
  end

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= TX_IDLE;
      timer_q <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - 8N1, 7E2 and 7O1 transmitters checked cycle by cycle against a frame-level model
module tb_uart_tx_fifo;

  localparam int NI    = 3;
  localparam int CPB   = 10;
  localparam int DEPTH = 8;
  localparam int DBS  [NI] = '{8, 7, 7};
  localparam int PARS [NI] = '{0, 2, 1};
  localparam int SBS  [NI] = '{1, 2, 1};

  logic          clk_50M = 1'b0;
  logic          rst_n;
  logic [8:0]    in_data_v [NI];
  logic [NI-1:0] in_valid_v;
  logic [NI-1:0] in_ready_v;
  logic [NI-1:0] tx_v;
  logic [NI-1:0] busy_v;
  logic [NI-1:0] done_v;
  logic [3:0]    fcnt_v [NI];

  int n_checks = 0;
  int n_pass   = 0;

  int mq  [NI][$];
  bit act [NI];
  int pos [NI];
  int cur [NI];

  always #5 clk_50M = ~clk_50M;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    uart_tx_fifo #(
      .CLK_HZ    (1_000_000),
      .BAUD      (100_000),
      .DATA_BITS (DBS[g]),
      .PARITY    (PARS[g]),
      .STOP_BITS (SBS[g]),
      .FIFO_DEPTH(DEPTH)
    ) u_dut (
      .clk_50M   (clk_50M),
      .rst_n     (rst_n),
      .in_data   (in_data_v[g][DBS[g]-1:0]),
      .in_valid  (in_valid_v[g]),
      .in_ready  (in_ready_v[g]),
      .tx        (tx_v[g]),
      .busy      (busy_v[g]),
      .frame_done(done_v[g]),
      .fifo_count(fcnt_v[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
  endtask

  function automatic int word_mask(input int i);
    return (1 << DBS[i]) - 1;
  endfunction

  function automatic int flen(input int i);
    return (1 + DBS[i] + ((PARS[i] != 0) ? 1 : 0) + SBS[i]) * CPB;
  endfunction

  // Line level of bit slot idx within a frame: start, data LSB first, optional parity, stops.
  function automatic logic line_bit(input int i, input int word, input int idx);
    logic p;
    if (idx == 0) return 1'b0;
    if (idx <= DBS[i]) return word[idx-1];
    if (PARS[i] != 0 && idx == DBS[i] + 1) begin
      p = ^(word & word_mask(i));
      return (PARS[i] == 1) ? ~p : p;
    end
    return 1'b1;
  endfunction

  task automatic model_reset(input int i);
    mq[i].delete();
    act[i] = 1'b0;
    pos[i] = 0;
  endtask

  task automatic model_step(input int i);
    int pre;
    pre = mq[i].size();
    if (act[i]) begin
      pos[i]++;
      if (pos[i] == flen(i)) act[i] = 1'b0;
    end
    if (!act[i] && pre > 0) begin
      cur[i] = mq[i].pop_front();
      act[i] = 1'b1;
      pos[i] = 0;
    end
    if (in_valid_v[i] && pre < DEPTH) mq[i].push_back(int'(in_data_v[i]) & word_mask(i));
  endtask

  function automatic logic [7:0] expected(input int i);
    logic t;
    logic b;
    logic d;
    logic r;
    t = act[i] ? line_bit(i, cur[i], pos[i] / CPB) : 1'b1;
    b = act[i] || (mq[i].size() > 0);
    d = act[i] && (pos[i] == flen(i) - 1);
    r = mq[i].size() < DEPTH;
    return {t, b, d, r, 4'(mq[i].size())};
  endfunction

  initial begin : monitor
    forever begin
      @(posedge clk_50M);
      for (int i = 0; i < NI; i++) begin
        if (!rst_n) model_reset(i);
        else        model_step(i);
      end
      #1;
      for (int i = 0; i < NI; i++)
        check($sformatf("cfg%0d_line", i),
              {24'd0, tx_v[i], busy_v[i], done_v[i], in_ready_v[i], fcnt_v[i]},
              {24'd0, expected(i)});
    end
  end

  task automatic drive(input logic [NI-1:0] v, input logic [8:0] d0, input logic [8:0] d1,
                       input logic [8:0] d2);
    @(negedge clk_50M);
    in_valid_v   = v;
    in_data_v[0] = d0;
    in_data_v[1] = d1;
    in_data_v[2] = d2;
  endtask

  task automatic idle(input int n);
    repeat (n) drive('0, 9'd0, 9'd0, 9'd0);
  endtask

  initial begin : stimulus
    rst_n      = 1'b0;
    in_valid_v = '0;
    for (int i = 0; i < NI; i++) in_data_v[i] = '0;
    repeat (3) @(negedge clk_50M);
    rst_n = 1'b1;
    idle(50);

    drive('1, 9'h0A5, 9'h003, 9'h003);
    idle(130);

    // Fill the FIFO behind a frame in flight; the ninth word must be rejected.
    drive('1, 9'h055, 9'h055, 9'h055);
    for (int w = 1; w <= 9; w++) drive('1, 9'(w), 9'(w), 9'(w));
    idle(1300);

    drive('1, 9'h03C, 9'h01C, 9'h01C);
    drive('1, 9'h0C3, 9'h063, 9'h063);
    idle(250);

    for (int c = 0; c < 3000; c++) begin
      logic [NI-1:0] v;
      for (int i = 0; i < NI; i++) v[i] = ($urandom_range(0, 15) == 0);
      drive(v, 9'($urandom), 9'($urandom), 9'($urandom));
    end
    idle(1300);

    // Queue extra words, then reset during data bit 4 of the first frame.
    drive('1, 9'h06E, 9'h06E, 9'h06E);
    drive('1, 9'h011, 9'h011, 9'h011);
    drive('1, 9'h022, 9'h022, 9'h022);
    idle(52);
    rst_n = 1'b0;
    #1;
    check("rst_tx", {29'd0, tx_v}, 32'd7);
    check("rst_busy", {29'd0, busy_v}, 32'd0);
    check("rst_done", {29'd0, done_v}, 32'd0);
    for (int i = 0; i < NI; i++) check($sformatf("rst_count%0d", i), {28'd0, fcnt_v[i]}, 32'd0);
    repeat (2) @(negedge clk_50M);
    rst_n = 1'b1;
    idle(200);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised UART transmitter that replaces the fixed 8N1 transmitter in the UART block. It accepts words over a valid/ready handshake into an internal FIFO, then serialises each word LSB-first with a configurable data width, parity and stop-bit count at a baud rate derived from parameters. It drives the board TX line and feeds status back to the CPU-side UART register interface.

## Interface
- `CLK_HZ`, 50_000_000, input clock frequency in Hz.
- `BAUD`, 115_200, line rate in bit/s.
- `DATA_BITS`, 8, data bits per frame; legal range 5..9.
- `PARITY`, 0, parity mode: 0 none, 1 odd, 2 even.
- `STOP_BITS`, 1, stop bits per frame; legal values 1 or 2.
- `FIFO_DEPTH`, 8, FIFO depth in words; power of two, at least 2.
- `clk_50M  in  1`  system clock; all logic is on the rising edge.
- `rst_n  in  1`  asynchronous active-low reset.
- `in_data  in  DATA_BITS`  word to transmit.
- `in_valid  in  1`  `in_data` is valid.
- `in_ready  out  1`  FIFO can accept a word; equals `!fifo_full`.
- `tx  out  1`  serial line; idles high.
- `busy  out  1`  a frame is on the line or the FIFO is non-empty.
- `frame_done  out  1`  one-cycle pulse in the last cycle of each frame's final stop bit.
- `fifo_count  out  $clog2(FIFO_DEPTH)+1`  words currently queued.

## Operation
- Elaboration fails if `DATA_BITS`, `PARITY`, `STOP_BITS` or `FIFO_DEPTH` is outside its legal range.
- `CPB = (CLK_HZ + BAUD/2) / BAUD` (rounded). The defaults give 434. Every bit lasts exactly `CPB` cycles.
- A word is accepted on a rising edge where `in_valid && in_ready`. A push to a full FIFO is ignored and leaves the FIFO unchanged.
- A write while full is rejected even if a pop happens on the same edge. A push and a pop on the same edge while not full both take effect, and `fifo_count` does not change.
- State machine:
  - IDLE→START when the FIFO is non-empty. The word is popped into the shift register on that edge.
  - START (tx=0)→DATA.
  - DATA shifts out `DATA_BITS` bits LSB first, then goes to PARITY if `PARITY != 0`, otherwise to STOP.
  - PARITY sends XOR of the data bits for even parity, or its inverse for odd parity, then goes to STOP.
  - STOP (tx=1) lasts `STOP_BITS*CPB` cycles.
  - At the end of STOP, the state goes to START with an immediate pop if the FIFO is non-empty; otherwise it goes to IDLE.
- Counters: the bit-timer counts 0..CPB-1 and the bit-index counts 0..DATA_BITS-1. Both restart at 0 on every state change.

## Timing
- Reset values: `tx`=1, `in_ready`=1, `busy`=0, `frame_done`=0, `fifo_count`=0. The FIFO is emptied and the FSM is in IDLE.
- Reset asserted mid-frame drives `tx` to 1 immediately (asynchronously) and discards the frame in flight and all queued words.
- Latency: when a word is accepted at edge N into an empty, idle block, `tx` falls at edge N+1.
- Frame length is `(1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * CPB` cycles.
- Back-to-back frames have no idle gap. The next start bit begins on the edge after the last stop-bit cycle.
- `frame_done` is high for exactly one cycle per frame.
- `busy` falls on the same edge that the FSM returns to IDLE.
- All outputs are registered except `in_ready`, which is combinational from `fifo_count`.

## Structure
- Package `uart_pkg` contains:
  - the `parity_e` enum (NONE, ODD, EVEN);
  - the `tx_state_e` enum (IDLE, START, DATA, PARITY, STOP);
  - the function `clks_per_bit(clk_hz, baud)`, shared with the future receiver.
- Sub-module `uart_fifo` (parameters `WIDTH`, `DEPTH`) provides a synchronous FIFO with `push`/`pop`, `full`/`empty` and `count`, and uses the same async active-low reset.
- The FSM, baud timer and shifter live in the top module.

## Test plan
Use `CLK_HZ=1_000_000` and `BAUD=100_000`, which gives `CPB=10`.
- **Reset and idle:** hold `rst_n` low for 3 cycles, then release. Required: `tx`=1, `busy`=0, `in_ready`=1, `fifo_count`=0 for 50 cycles.
- **8N1 frame:** push 0xA5. Required: `tx` falls 1 cycle later, then shows line bits 0,1,0,1,0,0,1,0,1 and 1 (start, data LSB first, stop), each exactly 10 cycles. `frame_done` pulses at cycle 100.
- **7E2 and 7O1 frames:**
  - 7E2: push 0x03. Required: parity bit 0, two stop bits, frame of 110 cycles.
  - 7O1: push 0x03. Required: parity bit 1, frame of 100 cycles.
- **FIFO full:** push 9 words (0x01..0x09) on consecutive cycles with `FIFO_DEPTH=8` while a frame is in flight. Required:
  - `in_ready` drops once 8 words are queued, and the rejected word is never transmitted;
  - all accepted words are sent in order with no gap between frames;
  - `busy` falls after the last stop bit.
- **Simultaneous push/pop:** push a word on the exact edge where the FSM pops from a one-entry FIFO. Required: `fifo_count` stays at 1 and both words are sent.
- **Reset mid-frame:** assert `rst_n` during data bit 4. Required: `tx`=1 within the same cycle, `fifo_count`=0, and after release no residual frame is sent.
